// File: rtl/fixed_pt_divider.sv
// Signed Q-format divider: quotient = (dividend << DECIMAL_PLACE) / divisor.
// Restoring shift-subtract, one quotient bit per clock, valid/ready on both sides.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake (ready only in IDLE)
//   dividend, divisor     signed Q-format operands
//   out_valid / out_ready result handshake (result held until accepted)
//   quotient              signed Q-format result, saturated on overflow
//   overflow              true quotient not representable
//   div_by_zero           divisor was zero
module fixed_pt_divider #(
  parameter int OPERAND_WIDTH = 24,
  parameter int DECIMAL_PLACE = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPERAND_WIDTH-1:0] dividend,
  input  logic [OPERAND_WIDTH-1:0] divisor,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPERAND_WIDTH-1:0] quotient,
  output logic                     overflow,
  output logic                     div_by_zero
);

  localparam int W  = OPERAND_WIDTH;
  localparam int D  = DECIMAL_PLACE;
  localparam int N  = W + D;
  localparam int CW = $clog2(N);

  localparam logic [W-1:0] QMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] QMIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIX,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [W-1:0]  mag_b;
  logic [W-1:0]  rem;
  logic [N-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          neg;

  logic [W:0]    trial;
  logic          ge;
  logic [W-1:0]  rem_nx;
  logic [N-1:0]  acc_nx;

  logic [W-1:0]  fix_q;
  logic          fix_ovf;
  logic          big_pos;
  logic          big_neg;

  logic          accept;
  logic          zero_div;

  function automatic logic [W-1:0] mag(
    input logic [W-1:0] v
  );
    return v[W-1] ? (~v + 1'b1) : v;
  endfunction

  assign accept   = in_valid && (state == IDLE);
  assign zero_div = (divisor == '0);

  // acc holds the numerator shifting out of the top while
  // quotient bits shift in at the bottom.
  always_comb begin
    trial  = {rem, acc[N-1]};
    ge     = (trial >= {1'b0, mag_b});
    rem_nx = ge ? W'(trial - {1'b0, mag_b}) : trial[W-1:0];
    acc_nx = {acc[N-2:0], ge};
  end

  // Negative side may reach exactly 2^(W-1).
  always_comb begin
    big_pos = |acc[N-1:W-1];
    big_neg = (|acc[N-1:W]) || (acc[W-1] && (|acc[W-2:0]));
    fix_q   = acc[W-1:0];
    fix_ovf = 1'b0;
    if (neg) begin
      if (big_neg) begin
        fix_q   = QMIN;
        fix_ovf = 1'b1;
      end else begin
        fix_q = ~acc[W-1:0] + 1'b1;
      end
    end else if (big_pos) begin
      fix_q   = QMAX;
      fix_ovf = 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = zero_div ? FIX : DIV;
        end
      end
      DIV: begin
        if (cnt == CW'(N - 1)) begin
          state_nx = FIX;
        end
      end
      FIX: begin
        state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Zero divisor skips DIV; its saturated result is set at accept
  // and FIX passes it through untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quotient    <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      mag_b       <= '0;
      rem         <= '0;
      acc         <= '0;
      cnt         <= '0;
      neg         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            acc   <= {mag(dividend), {D{1'b0}}};
            mag_b <= mag(divisor);
            rem   <= '0;
            cnt   <= '0;
            neg   <= dividend[W-1] ^ divisor[W-1];
            if (zero_div) begin
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              quotient    <= dividend[W-1] ? QMIN : QMAX;
            end
          end
        end
        DIV: begin
          acc <= acc_nx;
          rem <= rem_nx;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          if (!div_by_zero) begin
            quotient <= fix_q;
            overflow <= fix_ovf;
          end
        end
        DONE: begin
          if (out_ready) begin
            quotient    <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_pt_divider.sv
// Directed self-checking bench for fixed_pt_divider.
// Hand-computed Q12.12 vectors, latency, hold, and reset-abort checks.
module tb_fixed_pt_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] dividend;
  logic [23:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] quotient;
  logic        overflow;
  logic        div_by_zero;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fixed_pt_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_op(
    input string       tag,
    input logic [23:0] a,
    input logic [23:0] b,
    input logic [23:0] q,
    input logic        ovf,
    input logic        dbz,
    input int          lat
  );
    int n;
    @(negedge clk);
    chk({tag, ".rdy_in"}, 32'(in_ready), 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(lat));
    chk({tag, ".q"}, 32'(quotient), 32'(q));
    chk({tag, ".ovf"}, 32'(overflow), 32'(ovf));
    chk({tag, ".dbz"}, 32'(div_by_zero), 32'(dbz));
    chk({tag, ".busy"}, 32'(in_ready), 32'd0);
  endtask

  task automatic ack(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".ov_clr"}, 32'(out_valid), 32'd0);
    chk({tag, ".rdy_back"}, 32'(in_ready), 32'd1);
    chk({tag, ".flg_clr"}, 32'({overflow, div_by_zero}), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.quotient", 32'(quotient), 32'd0);
    chk("rst.flags", 32'({overflow, div_by_zero}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("3/2", 24'h003000, 24'h002000, 24'h001800, 0, 0, 37);
    ack("3/2");
    run_op("-1/3", 24'hFFF000, 24'h003000, 24'hFFFAAB, 0, 0, 37);
    ack("-1/3");
    run_op("posovf", 24'h7FF000, 24'h000001, 24'h7FFFFF, 1, 0, 37);
    ack("posovf");
    run_op("minexact", 24'h800000, 24'h001000, 24'h800000, 0, 0, 37);
    ack("minexact");
    run_op("negovf", 24'h800000, 24'h000FFF, 24'h800000, 1, 0, 37);
    ack("negovf");
    run_op("maxexact", 24'h7FFFFF, 24'h001000, 24'h7FFFFF, 0, 0, 37);
    ack("maxexact");
    run_op("min/min", 24'h800000, 24'h800000, 24'h001000, 0, 0, 37);
    ack("min/min");
    run_op("1/-1", 24'h001000, 24'hFFF000, 24'hFFF000, 0, 0, 37);
    ack("1/-1");
    run_op("negzero", 24'hFFFFFF, 24'h7FFFFF, 24'h000000, 0, 0, 37);
    ack("negzero");
    run_op("min/-ulp", 24'h800000, 24'hFFFFFF, 24'h7FFFFF, 1, 0, 37);
    ack("min/-ulp");
    run_op("dz.neg", 24'hFFF000, 24'h000000, 24'h800000, 0, 1, 1);
    ack("dz.neg");
    run_op("dz.zero", 24'h000000, 24'h000000, 24'h7FFFFF, 0, 1, 1);
    ack("dz.zero");

    run_op("hold", 24'h003000, 24'h002000, 24'h001800, 0, 0, 37);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 24'h001000;
      divisor  = 24'h000000;
      @(posedge clk);
      #1;
      chk("hold.valid", 32'(out_valid), 32'd1);
      chk("hold.q", 32'(quotient), 32'h001800);
      chk("hold.flags", 32'({overflow, div_by_zero}), 32'd0);
      chk("hold.rdy", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    ack("hold");
    run_op("b2b", 24'hFFF000, 24'h003000, 24'hFFFAAB, 0, 0, 37);
    ack("b2b");

    @(negedge clk);
    dividend = 24'h003000;
    divisor  = 24'h002000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort.in_ready", 32'(in_ready), 32'd1);
    chk("abort.out_valid", 32'(out_valid), 32'd0);
    chk("abort.q", 32'(quotient), 32'd0);
    chk("abort.flags", 32'({overflow, div_by_zero}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post", 24'h001000, 24'hFFF000, 24'hFFF000, 0, 0, 37);
    ack("post");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
